// File: rtl/vip_matrix_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vip_matrix_window_ctrl
// Description : Sequencer in front of the 3x3 Bayer matrix generator.
//               Forwards the sensor stream to the generator with one cycle
//               of latency and tracks input frame/line position. After the
//               last sensor line it injects one all-zero flush line so the
//               generator emits the windows centred on the bottom row. On
//               the generator's return side it counts position and qualifies
//               complete 3x3 windows, their centre coordinates and borders.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 pixel clock, synchronous active-high reset
//   cfg_en                   enable, sampled on the frame-start vsync edge
//   per_frame_*/per_img_y    sensor vsync/href/clken/pixel
//   gen_frame_*/gen_img_y    stream to the generator (sensor or flush line)
//   mat_frame_href/clken     timing returned by the generator
//   win_valid, win_x, win_y  complete-window qualifier and centre position
//   bdr_top/bot/left/right   centre lies on the corresponding image border
//   busy, frame_done         sequencer active / end-of-frame pulse
//   err_len, err_ovr         sticky length and overrun errors
// ============================================================================
module vip_matrix_window_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int CW        = 12,
    parameter int FLUSH_GAP = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic          per_frame_vsync,
    input  logic          per_frame_href,
    input  logic          per_frame_clken,
    input  logic [7:0]    per_img_y,
    output logic          gen_frame_vsync,
    output logic          gen_frame_href,
    output logic          gen_frame_clken,
    output logic [7:0]    gen_img_y,
    input  logic          mat_frame_href,
    input  logic          mat_frame_clken,
    output logic          win_valid,
    output logic [CW-1:0] win_x,
    output logic [CW-1:0] win_y,
    output logic          bdr_top,
    output logic          bdr_bot,
    output logic          bdr_left,
    output logic          bdr_right,
    output logic          busy,
    output logic          frame_done,
    output logic          err_len,
    output logic          err_ovr
);

    // Flush sequence: gap, IMG_W strobed pixels, gap
    localparam int c_FL_TOT = 2 * FLUSH_GAP + IMG_W;
    localparam int c_FLW    = $clog2(c_FL_TOT + 1);

    localparam logic [CW-1:0]    c_ONE     = CW'(1);
    localparam logic [CW-1:0]    c_W       = CW'(IMG_W);
    localparam logic [CW-1:0]    c_W_M1    = CW'(IMG_W - 1);
    localparam logic [CW-1:0]    c_H       = CW'(IMG_H);
    localparam logic [CW-1:0]    c_CMAX    = {CW{1'b1}};
    localparam logic [c_FLW-1:0] c_FL_HS   = c_FLW'(FLUSH_GAP);
    localparam logic [c_FLW-1:0] c_FL_HE   = c_FLW'(FLUSH_GAP + IMG_W);
    localparam logic [c_FLW-1:0] c_FL_LAST = c_FLW'(c_FL_TOT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_in_href;
    logic [CW-1:0]    r_in_col;
    logic [CW-1:0]    r_in_row;
    logic [c_FLW-1:0] r_fl_cnt;
    logic             r_mat_href;
    logic [CW-1:0]    r_oc;
    logic [CW-1:0]    r_or;

    logic             w_vs_rise;
    logic             w_in_fall;
    logic             w_in_pix;
    logic [CW-1:0]    w_in_row_inc;
    logic             w_active;
    logic             w_last_line;
    logic             w_fl_end;
    logic             w_fl_href;
    logic             w_use_flush;
    logic             w_mat_fall;
    logic             w_len_err;
    logic             w_ovr_err;

    // ------------------------------------------------------------------
    // Event decode. gen_frame_vsync doubles as the previous vsync sample.
    // ------------------------------------------------------------------
    assign w_vs_rise    = per_frame_vsync & ~gen_frame_vsync;
    assign w_in_fall    = r_in_href & ~per_frame_href;
    assign w_in_pix     = per_frame_href & per_frame_clken;
    assign w_in_row_inc = (r_in_row == c_CMAX) ? r_in_row : r_in_row + c_ONE;
    // A vsync restart pre-empts every other input-side event that cycle
    assign w_active     = (r_state == S_ACTIVE) & ~w_vs_rise;
    assign w_last_line  = w_active & w_in_fall & (w_in_row_inc >= c_H);
    assign w_fl_end     = (r_state == S_FLUSH) & (r_fl_cnt == c_FL_LAST);
    assign w_fl_href    = (r_fl_cnt >= c_FL_HS) & (r_fl_cnt < c_FL_HE);
    assign w_use_flush  = (r_state == S_FLUSH) & ~w_vs_rise;
    assign w_mat_fall   = r_mat_href & ~mat_frame_href & ~w_vs_rise;

    assign w_len_err = (w_active & w_in_fall & (r_in_col != c_W))
                     | (w_active & w_in_fall & (r_in_row == c_CMAX))
                     | (w_active & ~w_in_fall & w_in_pix & (r_in_col == c_CMAX))
                     | (w_last_line & (w_in_row_inc != c_H));

    assign w_ovr_err = (w_vs_rise & (r_state != S_IDLE))
                     | ((r_state == S_FLUSH) & per_frame_clken);

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_rise) begin
            w_state_nxt = cfg_en ? S_ACTIVE : S_IDLE;
        end else begin
            case (r_state)
                S_ACTIVE: if (w_last_line) w_state_nxt = S_FLUSH;
                S_FLUSH:  if (w_fl_end)    w_state_nxt = S_DONE;
                S_DONE:   if (frame_done)  w_state_nxt = S_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Input-side position counters (saturating)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_href <= 1'b0;
            r_in_col  <= '0;
            r_in_row  <= '0;
        end else begin
            r_in_href <= per_frame_href;
            if (w_vs_rise) begin
                r_in_col <= '0;
                r_in_row <= '0;
            end else if (w_active) begin
                if (w_in_fall) begin
                    r_in_col <= '0;
                    r_in_row <= w_in_row_inc;
                end else if (w_in_pix && (r_in_col != c_CMAX)) begin
                    r_in_col <= r_in_col + c_ONE;
                end
            end
        end
    end

    // Flush-line position; idles at zero outside FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fl_cnt <= '0;
        end else if (w_use_flush && !w_fl_end) begin
            r_fl_cnt <= r_fl_cnt + 1'b1;
        end else begin
            r_fl_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Generator feed: sensor stream, or the synthetic flush line
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gen_frame_vsync <= 1'b0;
            gen_frame_href  <= 1'b0;
            gen_frame_clken <= 1'b0;
            gen_img_y       <= 8'd0;
        end else begin
            gen_frame_vsync <= per_frame_vsync;
            if (w_use_flush) begin
                gen_frame_href  <= w_fl_href;
                gen_frame_clken <= w_fl_href;
                gen_img_y       <= 8'd0;
            end else begin
                gen_frame_href  <= per_frame_href;
                gen_frame_clken <= per_frame_clken;
                gen_img_y       <= per_img_y;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output-side position counters. or reaches IMG_H on the flush line
    // and wraps to 0 when that line ends.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mat_href <= 1'b0;
            r_oc       <= '0;
            r_or       <= '0;
            frame_done <= 1'b0;
        end else begin
            r_mat_href <= mat_frame_href;
            frame_done <= w_mat_fall & (r_or == c_H);
            if (w_vs_rise) begin
                r_oc <= '0;
                r_or <= '0;
            end else if (w_mat_fall) begin
                r_oc <= '0;
                r_or <= (r_or >= c_H) ? '0 : r_or + c_ONE;
            end else if (mat_frame_href && mat_frame_clken && (r_oc < c_W_M1)) begin
                r_oc <= r_oc + c_ONE;
            end
        end
    end

    // Window centre lags the newest column/row by one
    assign win_valid = mat_frame_clken & mat_frame_href & (r_oc != '0) & (r_or != '0);
    assign win_x     = win_valid ? (r_oc - c_ONE) : '0;
    assign win_y     = win_valid ? (r_or - c_ONE) : '0;
    assign bdr_top   = win_valid & (r_or == c_ONE);
    assign bdr_bot   = win_valid & (r_or == c_H);
    assign bdr_left  = win_valid & (r_oc == c_ONE);
    assign bdr_right = win_valid & (r_oc == c_W_M1);

    // ------------------------------------------------------------------
    // Sticky errors
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len <= 1'b0;
            err_ovr <= 1'b0;
        end else begin
            if (w_len_err) err_len <= 1'b1;
            if (w_ovr_err) err_ovr <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vip_matrix_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vip_matrix_window_ctrl
// Description : Directed self-checking bench for vip_matrix_window_ctrl with
//               a 4x3 image. The generator is modelled as a two-cycle delay
//               of the href/clken it is fed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vip_matrix_window_ctrl;

    localparam int W   = 4;
    localparam int H   = 3;
    localparam int CWB = 12;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cfg_en = 1'b0;
    logic           vs = 1'b0;
    logic           hr = 1'b0;
    logic           ck = 1'b0;
    logic [7:0]     yin = 8'd0;

    logic           gen_frame_vsync, gen_frame_href, gen_frame_clken;
    logic [7:0]     gen_img_y;
    logic           win_valid, bdr_top, bdr_bot, bdr_left, bdr_right;
    logic [CWB-1:0] win_x, win_y;
    logic           busy, frame_done, err_len, err_ovr;

    logic           d1_href = 1'b0, d1_clken = 1'b0;
    logic           d2_href = 1'b0, d2_clken = 1'b0;

    int             n_chk = 0, n_pass = 0, n_fail = 0;
    int             fd_cnt = 0, flush_px = 0, win_seen = 0;
    int             line_len[H];
    bit             err_exp = 1'b0;
    logic [10:0]    gq[$];
    int             wxq[$];
    int             wyq[$];

    vip_matrix_window_ctrl #(
        .IMG_W(W), .IMG_H(H), .CW(CWB), .FLUSH_GAP(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck), .per_img_y(yin),
        .gen_frame_vsync(gen_frame_vsync), .gen_frame_href(gen_frame_href),
        .gen_frame_clken(gen_frame_clken), .gen_img_y(gen_img_y),
        .mat_frame_href(d2_href), .mat_frame_clken(d2_clken),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .bdr_top(bdr_top), .bdr_bot(bdr_bot), .bdr_left(bdr_left), .bdr_right(bdr_right),
        .busy(busy), .frame_done(frame_done), .err_len(err_len), .err_ovr(err_ovr)
    );

    always #5 clk = ~clk;

    // Generator timing model
    always @(posedge clk) begin
        d1_href  <= gen_frame_href;
        d1_clken <= gen_frame_clken;
        d2_href  <= d1_href;
        d2_clken <= d1_clken;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input int obs, input int exp);
        n_chk++;
        n_fail++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic push_win(input int x, input int y);
        wxq.push_back(x);
        wyq.push_back(y);
    endtask

    // One clock: drive inputs, clock, then check generator feed and windows
    task automatic tick(input logic v, input logic h, input logic c, input logic [7:0] d,
                        input bit chk);
        logic [10:0] e;
        int ex, ey;
        vs = v; hr = h; ck = c; yin = d;
        if (chk) gq.push_back({v, h, c, d});
        @(posedge clk);
        #1;
        if (chk) begin
            e = gq.pop_front();
            check("gen_pass", 32'({gen_frame_vsync, gen_frame_href, gen_frame_clken, gen_img_y}),
                  32'(e));
        end else if (gen_frame_clken) begin
            flush_px++;
            check("flush_px_data", 32'({gen_frame_href, gen_img_y}), 32'({1'b1, 8'h00}));
        end
        if (frame_done) fd_cnt++;
        if (win_valid) begin
            if (wxq.size() == 0) begin
                fail_now("win_extra", int'(win_x), -1);
            end else begin
                ex = wxq.pop_front();
                ey = wyq.pop_front();
                win_seen++;
                check("win_xy", 32'({win_x, win_y}), 32'({12'(ex), 12'(ey)}));
                check("win_bdr", 32'({bdr_top, bdr_bot, bdr_left, bdr_right}),
                      32'({ey == 0, ey == H - 1, ex == 0, ex == W - 2}));
            end
        end
    endtask

    // One sensor frame. first_chk=0 marks a restart that lands in FLUSH;
    // abort leaves the frame two cycles into its flush sequence.
    task automatic frame(input bit first_chk, input bit exp_flush, input bit abort);
        int fd0, px0, ws0, nexp;
        fd0 = fd_cnt;
        ws0 = win_seen;
        nexp = 0;
        tick(1'b1, 1'b0, 1'b0, 8'd0, first_chk);
        if (!first_chk) check("ovr_restart", 32'({busy, err_ovr}), 32'(2'b11));
        tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        for (int r = 0; r < H; r++) begin
            if (r >= 1) begin
                for (int x = 0; x < line_len[r] - 1; x++) begin
                    push_win(x, r - 1);
                    nexp++;
                end
            end
            for (int c = 0; c < line_len[r]; c++)
                tick(1'b0, 1'b1, 1'b1, 8'(r * 16 + c + 1), 1'b1);
            if (exp_flush && line_len[r] != W) err_exp = 1'b1;
            tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
            check("err_len_line", 32'(err_len), 32'(err_exp));
            if (r < H - 1) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        end
        if (!exp_flush) begin
            repeat (20) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
            check("idle_busy", 32'(busy), 32'(0));
            check("idle_no_done", 32'(fd_cnt - fd0), 32'(0));
            check("idle_win_cnt", 32'(win_seen - ws0), 32'(nexp));
            return;
        end
        if (abort) begin
            tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            check("abort_win_cnt", 32'(win_seen - ws0), 32'(nexp));
            return;
        end
        for (int x = 0; x < W - 1; x++) begin
            push_win(x, H - 1);
            nexp++;
        end
        px0 = flush_px;
        for (int i = 0; i < 100 && fd_cnt == fd0; i++)
            tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        if (fd_cnt == fd0) fail_now("frame_done_timeout", fd_cnt - fd0, 1);
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check("flush_px_cnt", 32'(flush_px - px0), 32'(W));
        check("frame_done_cnt", 32'(fd_cnt - fd0), 32'(1));
        check("busy_end", 32'(busy), 32'(0));
        check("win_cnt", 32'(win_seen - ws0), 32'(nexp));
        check("win_drain", 32'(wxq.size()), 32'(0));
    endtask

    initial begin
        // Reset state
        repeat (3) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check("rst_a", 32'({win_valid, win_x, win_y, bdr_top, bdr_bot, bdr_left, bdr_right}), 32'(0));
        check("rst_b", 32'({busy, frame_done, err_len, err_ovr, gen_frame_href, gen_frame_clken}),
              32'(0));
        rst = 1'b0;
        cfg_en = 1'b1;

        // Clean frame: pass-through, flush line, nine windows, border flags
        line_len = '{W, W, W};
        frame(1'b1, 1'b1, 1'b0);
        check("clean_err", 32'({err_len, err_ovr}), 32'(0));

        // Short middle line
        line_len = '{W, 3, W};
        frame(1'b1, 1'b1, 1'b0);
        check("short_err", 32'({err_len, err_ovr}), 32'(2'b10));

        // Restart during FLUSH, then a normal frame
        line_len = '{W, W, W};
        frame(1'b1, 1'b1, 1'b1);
        frame(1'b0, 1'b1, 1'b0);
        check("ovr_sticky", 32'({err_len, err_ovr}), 32'(2'b11));

        // Disabled frame: stays idle, stream still forwarded
        cfg_en = 1'b0;
        frame(1'b1, 1'b0, 1'b0);
        wxq.delete();
        wyq.delete();

        // Reset in the middle of an active line
        cfg_en = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 8'h55, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 8'h66, 1'b1);
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        rst = 1'b0;
        check("mid_rst_a", 32'({win_valid, win_x, win_y, bdr_top, bdr_bot, bdr_left, bdr_right}),
              32'(0));
        check("mid_rst_b", 32'({busy, frame_done, err_len, err_ovr, gen_frame_vsync,
                                gen_frame_href, gen_frame_clken, gen_img_y}), 32'(0));
        repeat (4) tick(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        err_exp = 1'b0;
        frame(1'b1, 1'b1, 1'b0);
        check("post_rst_err", 32'({err_len, err_ovr}), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
